// File: rtl/color_pkg.sv
// Shared codes for the colour-sensor emulator: filter/scale pin encodings,
// scale multipliers and the output-phase state type.
package color_pkg;

    localparam logic [1:0] FILT_RED   = 2'd0;
    localparam logic [1:0] FILT_BLUE  = 2'd1;
    localparam logic [1:0] FILT_CLEAR = 2'd2;
    localparam logic [1:0] FILT_GREEN = 2'd3;

    // Scale codes are {s0,s1}
    localparam logic [1:0] SCALE_OFF = 2'b00;
    localparam logic [1:0] SCALE_2   = 2'b10;
    localparam logic [1:0] SCALE_20  = 2'b01;
    localparam logic [1:0] SCALE_100 = 2'b11;

    localparam int MULT_2   = 50;
    localparam int MULT_20  = 5;
    localparam int MULT_100 = 1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/color_hp_scaler.sv
// Selects the programmed half-period for the active filter and scales it by
// the output-frequency multiplier; a base of zero is treated as one.
module color_hp_scaler
    import color_pkg::*;
#(
    parameter int HP_W = 24
) (
    input  logic [3:0][HP_W-1:0] hp_regs_i,
    input  logic [1:0]           filt_i,
    input  logic [1:0]           scale_i,
    output logic [HP_W+5:0]      eff_hp_o
);

    logic [HP_W-1:0] base_sel;
    logic [HP_W+5:0] base_ext;

    always_comb begin
        base_sel = hp_regs_i[filt_i];
        base_ext = {6'd0, base_sel};
        if (base_sel == '0) begin
            base_ext = (HP_W+6)'(1);
        end
        // Six extra bits cover x50 of a full-scale base without overflow.
        case (scale_i)
            SCALE_2:  eff_hp_o = (base_ext << 5) + (base_ext << 4) + (base_ext << 1);
            SCALE_20: eff_hp_o = (base_ext << 2) + base_ext;
            default:  eff_hp_o = base_ext;
        endcase
    end

endmodule

// File: rtl/color_freq_emulator.sv
// TCS3200-style light-to-frequency emulator: square wave with per-filter
// programmable half-periods, scaled by the S0/S1 pins and gated by power-down.
module color_freq_emulator
    import color_pkg::*;
#(
    parameter int HP_W       = 24,
    parameter int DEFAULT_HP = 500
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s0,
    input  logic            s1,
    input  logic            s2,
    input  logic            s3,
    input  logic            wr_en,
    input  logic [1:0]      wr_sel,
    input  logic [HP_W-1:0] wr_data,
    output logic            freq_out,
    output logic            rise_stb,
    output logic            active
);

    localparam int EFF_W = HP_W + 6;

    state_t                state_q, state_d;
    logic [EFF_W-1:0]      cnt_q, cnt_d;
    logic                  rise_q, rise_d;
    logic [3:0][HP_W-1:0]  hp_q, hp_d;
    logic [EFF_W-1:0]      eff_hp;
    logic [1:0]            scale;
    logic [1:0]            filt;

    assign scale = {s0, s1};
    assign filt  = {s3, s2};

    color_hp_scaler #(
        .HP_W (HP_W)
    ) u_scaler (
        .hp_regs_i (hp_q),
        .filt_i    (filt),
        .scale_i   (scale),
        .eff_hp_o  (eff_hp)
    );

    // A write racing a reload is safe: the reload reads hp_q, the write lands in hp_d.
    always_comb begin
        hp_d = hp_q;
        if (wr_en) begin
            hp_d[wr_sel] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            hp_q    <= {4{HP_W'(DEFAULT_HP)}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            hp_q    <= hp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (scale != SCALE_OFF) begin
                    state_d = ST_LOW;
                    cnt_d   = eff_hp - EFF_W'(1);
                end
            end
            ST_LOW, ST_HIGH: begin
                if (scale == SCALE_OFF) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    // Filter/scale are only consulted here, so phases never glitch.
                    state_d = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
                    rise_d  = (state_q == ST_LOW);
                    cnt_d   = eff_hp - EFF_W'(1);
                end else begin
                    cnt_d = cnt_q - EFF_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        freq_out = (state_q == ST_HIGH);
        rise_stb = rise_q;
        active   = (state_q != ST_OFF);
    end

endmodule

// File: tb/tb_color_freq_emulator.sv
// Bench for color_freq_emulator: directed phase-length checks with literal
// expectations plus a randomized run against a time-stamped behavioural model.
module tb_color_freq_emulator;

    localparam int HP_W       = 24;
    localparam int DEFAULT_HP = 500;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            s0 = 1'b1, s1 = 1'b1, s2 = 1'b0, s3 = 1'b0;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_sel = 2'd0;
    logic [HP_W-1:0] wr_data = '0;
    logic            freq_out, rise_stb, active;

    int vectors = 0;
    int miscompares = 0;

    color_freq_emulator #(
        .HP_W       (HP_W),
        .DEFAULT_HP (DEFAULT_HP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s0       (s0),
        .s1       (s1),
        .s2       (s2),
        .s3       (s3),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .freq_out (freq_out),
        .rise_stb (rise_stb),
        .active   (active)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The model tracks the absolute cycle at which the current phase ends.
    longint m_regs [4];
    bit     m_on, m_lvl, m_rise;
    longint t_now = 0;
    longint phase_end = 0;
    bit     model_live = 1'b0;

    function automatic longint eff_of(int f, logic [1:0] sc);
        longint base, mult;
        base = (m_regs[f] == 0) ? 1 : m_regs[f];
        case (sc)
            2'b10:   mult = 50;
            2'b01:   mult = 5;
            default: mult = 1;
        endcase
        return base * mult;
    endfunction

    always @(posedge clk) begin
        logic [1:0] sc;
        int         f;
        sc = {s0, s1};
        f  = int'({s3, s2});
        t_now++;
        if (reset) begin
            m_on = 0; m_lvl = 0; m_rise = 0;
            for (int i = 0; i < 4; i++) m_regs[i] = DEFAULT_HP;
        end else begin
            if (!m_on) begin
                m_rise = 0;
                if (sc != 2'b00) begin
                    m_on = 1; m_lvl = 0;
                    phase_end = t_now + eff_of(f, sc);
                end
            end else if (sc == 2'b00) begin
                m_on = 0; m_lvl = 0; m_rise = 0;
            end else if (t_now == phase_end) begin
                m_rise = !m_lvl;
                m_lvl  = !m_lvl;
                phase_end = t_now + eff_of(f, sc);
            end else begin
                m_rise = 0;
            end
            if (wr_en) m_regs[wr_sel] = longint'(wr_data);
        end
        model_live = 1'b1;
        #2;
        vectors++;
        if (freq_out !== m_lvl || rise_stb !== m_rise || active !== m_on) begin
            miscompares++;
            $display("FAIL model t=%0d: freq/rise/active got %b%b%b want %b%b%b",
                     t_now, freq_out, rise_stb, active, m_lvl, m_rise, m_on);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Counts clock edges until freq_out changes from its present value.
    task automatic run_len(output int n);
        logic v;
        v = freq_out;
        n = 0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            n++;
            if (freq_out !== v) return;
        end
        n = -1;
    endtask

    task automatic wait_rise();
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (rise_stb === 1'b1) return;
        end
        check("rise_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [1:0] sel, input int val);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_data = HP_W'(val);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_freq", int'(freq_out), 0);
        check("reset_active", int'(active), 0);
        check("reset_rise", int'(rise_stb), 0);

        // Defaults, red, 100%: one OFF edge then a 500-cycle LOW phase.
        reset = 1'b0;
        run_len(n); check("first_rise_latency", n, 501);
        run_len(n); check("default_high", n, 500);
        run_len(n); check("default_low", n, 500);

        do_write(FILT_RED_C(), 10);
        wait_rise(); wait_rise();
        run_len(n); check("red10_high", n, 10);
        run_len(n); check("red10_low", n, 10);

        @(negedge clk); s0 = 1'b0; s1 = 1'b1;
        wait_rise(); wait_rise();
        run_len(n); check("red10_x5_high", n, 50);

        @(negedge clk); s0 = 1'b1; s1 = 1'b0;
        wait_rise(); wait_rise();
        run_len(n); check("red10_x50_high", n, 500);

        // Filter change inside a HIGH phase only affects the next phase.
        @(negedge clk); s0 = 1'b1; s1 = 1'b1;
        do_write(2'd3, 30);
        wait_rise(); wait_rise();
        @(negedge clk); @(negedge clk);
        s3 = 1'b1; s2 = 1'b1;
        run_len(n); check("high_not_truncated", n, 9);
        run_len(n); check("green30_low", n, 30);

        // Power-down in HIGH, then restart.
        wait_rise();
        @(negedge clk); s0 = 1'b0; s1 = 1'b0;
        @(posedge clk); #1;
        check("pd_freq", int'(freq_out), 0);
        check("pd_active", int'(active), 0);
        check("pd_rise", int'(rise_stb), 0);
        repeat (3) @(negedge clk);
        s0 = 1'b1; s1 = 1'b1;
        run_len(n); check("restart_latency", n, 31);

        // Zero half-period behaves as one.
        do_write(2'd3, 0);
        wait_rise(); wait_rise();
        run_len(n); check("hp0_high", n, 1);
        run_len(n); check("hp0_low", n, 1);

        // Reset mid-phase restores DEFAULT_HP on all channels.
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_freq", int'(freq_out), 0);
        check("midreset_active", int'(active), 0);
        @(negedge clk); reset = 1'b0;
        run_len(n); check("post_reset_latency", n, 501);

        // Write coinciding with a reload.
        @(negedge clk); s3 = 1'b0; s2 = 1'b0;
        do_write(2'd0, 10);
        wait_rise(); wait_rise();
        repeat (10) @(negedge clk);
        wr_en = 1'b1; wr_sel = 2'd0; wr_data = HP_W'(4);
        @(negedge clk); wr_en = 1'b0;
        run_len(n); check("reload_uses_old", n, 10);
        run_len(n); check("reload_next_new", n, 4);

        // Randomized run; the per-cycle model does the checking.
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            wr_en = 1'b0;
            reset = 1'b0;
            if ($urandom_range(39) == 0) begin
                case ($urandom_range(9))
                    0:       {s0, s1} = 2'b00;
                    1:       {s0, s1} = 2'b10;
                    2, 3, 4: {s0, s1} = 2'b01;
                    default: {s0, s1} = 2'b11;
                endcase
            end
            if ($urandom_range(19) == 0) {s3, s2} = 2'($urandom_range(3));
            if ($urandom_range(9) == 0) begin
                wr_en   = 1'b1;
                wr_sel  = 2'($urandom_range(3));
                wr_data = HP_W'($urandom_range(15));
            end
            if ($urandom_range(1999) == 0) reset = 1'b1;
        end
        @(negedge clk);
        wr_en = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic [1:0] FILT_RED_C();
        return 2'd0;
    endfunction

endmodule
